lcd_scanout: RTL and testbench

LCD_SCANOUT -- requirements
Module: lcd_scanout

---
 rtl/lcd_scanout.sv | 184 ++++++++++++++++++
 tb/tb_lcd_scanout.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_scanout.sv
// Parallel-RGB LCD scan-out: sync/DEN timing, pixel FIFO with frame resync, sticky underflow.
// Optional colour-bar generator is compiled in with `define LCD_TEST_PATTERN_EN.
module lcd_scanout #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 13,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] pix_data,
    input  logic        pix_sof,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [23:0] RGB,
    output logic        DEN,
    output logic        HSD,
    output logic        VSD,
    input  logic        test_en,
    input  logic        underflow_clr,
    output logic        underflow,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic          run_reg;
    logic [HW-1:0] h_cnt_reg, h_cnt_next;
    logic [VW-1:0] v_cnt_reg, v_cnt_next;
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic [24:0]   fifo_mem [FIFO_DEPTH];
    logic [24:0]   head_word;
    logic          lost_sync_reg, lost_sync_next;
    logic [23:0]   rgb_reg, rgb_next;
    logic          den_reg, hsd_reg, vsd_reg, frame_start_reg;
    logic          underflow_reg, underflow_next;
    logic          fifo_empty, fifo_full, push, pop, discard, uf_event;
    logic          h_active, v_active, pix_active, at_origin, h_sync, v_sync;
    logic          pattern_mode;
    logic [23:0]   pattern_rgb;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pix_ready  = run_reg && !fifo_full;
    assign push       = pix_valid && pix_ready;
    assign head_word  = fifo_mem[rd_ptr_reg[AW-1:0]];

    assign h_active   = (h_cnt_reg < H_ACT_END);
    assign v_active   = (v_cnt_reg < V_ACT_END);
    assign pix_active = run_reg && h_active && v_active;
    assign at_origin  = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    assign h_sync     = (h_cnt_reg >= HS_FIRST) && (h_cnt_reg <= HS_LAST);
    assign v_sync     = (v_cnt_reg >= VS_FIRST) && (v_cnt_reg <= VS_LAST);

`ifdef LCD_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
    logic [6:0] bar_past;
    logic [2:0] bar_idx;
    genvar gi;
    // Thermometer of bar boundaries already passed on this line gives the bar index.
    for (gi = 0; gi < 7; gi++) begin : g_bar_edge
        assign bar_past[gi] = (h_cnt_reg >= HW'((gi + 1) * BAR_W));
    end
    assign bar_idx      = 3'($countones(bar_past));
    assign pattern_rgb  = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
    assign pattern_mode = test_en;
`else
    logic unused_test_en;
    assign unused_test_en = test_en;
    assign pattern_rgb    = '0;
    assign pattern_mode   = 1'b0;
`endif

    always_comb begin
        h_cnt_next = h_cnt_reg;
        v_cnt_next = v_cnt_reg;
        if (run_reg) begin
            if (h_cnt_reg == H_LAST) begin
                h_cnt_next = '0;
                v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
            end else begin
                h_cnt_next = h_cnt_reg + 1'b1;
            end
        end
    end

    // Pixel sourcing: only an sof word may open a frame, and an sof word seen
    // anywhere else kills the rest of that frame until vertical blanking.
    always_comb begin
        pop            = 1'b0;
        discard        = 1'b0;
        uf_event       = 1'b0;
        rgb_next       = '0;
        lost_sync_next = lost_sync_reg;
        if (run_reg && !v_active) begin
            lost_sync_next = 1'b0;
        end
        if (pattern_mode) begin
            if (pix_active) begin
                rgb_next = pattern_rgb;
            end
        end else if (pix_active) begin
            if (lost_sync_reg || fifo_empty) begin
                uf_event = 1'b1;
            end else if (head_word[24] != at_origin) begin
                uf_event       = 1'b1;
                lost_sync_next = 1'b1;
            end else begin
                pop      = 1'b1;
                rgb_next = head_word[23:0];
            end
        end else if (run_reg && !v_active && !fifo_empty && !head_word[24]) begin
            discard = 1'b1;
        end
        underflow_next = uf_event | (underflow_reg & ~underflow_clr);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= {pix_sof, pix_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_reg         <= 1'b0;
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            lost_sync_reg   <= 1'b0;
            rgb_reg         <= '0;
            den_reg         <= 1'b0;
            hsd_reg         <= 1'b1;
            vsd_reg         <= 1'b1;
            frame_start_reg <= 1'b0;
            underflow_reg   <= 1'b0;
        end else begin
            run_reg         <= 1'b1;
            h_cnt_reg       <= h_cnt_next;
            v_cnt_reg       <= v_cnt_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop || discard) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            lost_sync_reg   <= lost_sync_next;
            rgb_reg         <= rgb_next;
            den_reg         <= pix_active;
            hsd_reg         <= ~h_sync;
            vsd_reg         <= ~v_sync;
            frame_start_reg <= pix_active && at_origin;
            underflow_reg   <= underflow_next;
        end
    end

    assign RGB         = rgb_reg;
    assign DEN         = den_reg;
    assign HSD         = hsd_reg;
    assign VSD         = vsd_reg;
    assign frame_start = frame_start_reg;
    assign underflow   = underflow_reg;

endmodule

// File: tb/tb_lcd_scanout.sv
// Directed bench for lcd_scanout on a tiny 8x6-clock raster (4x3 visible, 4-deep FIFO).
module tb_lcd_scanout;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [23:0] pix_data = '0;
    logic        pix_sof = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [23:0] RGB;
    logic        DEN, HSD, VSD;
    logic        test_en = 1'b0;
    logic        underflow_clr = 1'b0;
    logic        underflow;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    logic [23:0] feed_data [32];
    logic        feed_sof  [32];
    int          feed_accepted;

    logic [23:0] cap_vals [12];
    int          cap_fs;
    logic        cap_uf;
    logic        cap_ok;

    lcd_scanout #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .RGB(RGB), .DEN(DEN), .HSD(HSD), .VSD(VSD),
        .test_en(test_en), .underflow_clr(underflow_clr),
        .underflow(underflow), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; underflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Reset, let frame 0 underflow, then clear the flag inside vertical blanking.
    task automatic reset_to_blanking();
        do_reset();
        repeat (30) @(negedge clk);
        underflow_clr = 1'b1;
        @(negedge clk);
        underflow_clr = 1'b0;
    endtask

    task automatic feeder(input int n, input int budget);
        int i;
        int t;
        i = 0; t = 0; feed_accepted = 0;
        while (i < n && t < budget) begin
            @(negedge clk);
            t++;
            pix_valid = 1'b1; pix_data = feed_data[i]; pix_sof = feed_sof[i];
            if (pix_ready === 1'b1) i++;
            feed_accepted = i;
        end
        @(negedge clk);
        pix_valid = 1'b0; pix_sof = 1'b0;
    endtask

    task automatic wait_frame_start(output bit ok);
        int g;
        g = 0;
        do begin @(negedge clk); g++; end while (frame_start !== 1'b1 && g < 200);
        ok = (frame_start === 1'b1);
    endtask

    task automatic wait_vsync(output bit ok);
        int g;
        g = 0;
        do begin @(negedge clk); g++; end while (VSD !== 1'b0 && g < 200);
        ok = (VSD === 1'b0);
    endtask

    // Records RGB of the 12 DEN cycles of the next frame.
    task automatic capture_frame();
        bit ok;
        int n;
        int g;
        n = 0; g = 0; cap_fs = 0;
        for (int i = 0; i < 12; i++) cap_vals[i] = 24'hDEAD00;
        wait_frame_start(ok);
        while (ok && n < 12 && g < 100) begin
            if (DEN === 1'b1) begin cap_vals[n] = RGB; n++; end
            if (frame_start === 1'b1) cap_fs++;
            if (n < 12) begin @(negedge clk); g++; end
        end
        cap_ok = ok && (n == 12);
        cap_uf = underflow;
    endtask

    task automatic test_reset();
        logic exp_den, exp_hsd, exp_vsd, exp_fs;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (DEN !== 1'b0) begin errors++; $display("FAIL rst_den: got %b want 0", DEN); end
        checks++; if (HSD !== 1'b1) begin errors++; $display("FAIL rst_hsd: got %b want 1", HSD); end
        checks++; if (VSD !== 1'b1) begin errors++; $display("FAIL rst_vsd: got %b want 1", VSD); end
        checks++; if (RGB !== 24'h0) begin errors++; $display("FAIL rst_rgb: got %h want 000000", RGB); end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", pix_ready); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst_underflow: got %b want 0", underflow); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL first_clk_ready: got %b want 1", pix_ready); end
        checks++; if (DEN !== 1'b0) begin errors++; $display("FAIL first_clk_den: got %b want 0", DEN); end
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            exp_den = ((k % 8) < 4) && ((k / 8) < 3);
            exp_hsd = !(((k % 8) == 5) || ((k % 8) == 6));
            exp_vsd = !((k / 8) == 4);
            exp_fs  = (k == 0);
            checks++; if (DEN !== exp_den) begin errors++; $display("FAIL timing_den k=%0d: got %b want %b", k, DEN, exp_den); end
            checks++; if (HSD !== exp_hsd) begin errors++; $display("FAIL timing_hsd k=%0d: got %b want %b", k, HSD, exp_hsd); end
            checks++; if (VSD !== exp_vsd) begin errors++; $display("FAIL timing_vsd k=%0d: got %b want %b", k, VSD, exp_vsd); end
            checks++; if (frame_start !== exp_fs) begin errors++; $display("FAIL timing_fs k=%0d: got %b want %b", k, frame_start, exp_fs); end
            checks++; if (RGB !== 24'h0) begin errors++; $display("FAIL timing_rgb k=%0d: got %h want 000000", k, RGB); end
        end
        $display("test_reset: %0d checks so far, %0d errors", checks, errors);
    endtask

    task automatic test_streaming();
        reset_to_blanking();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL stream_clr: got %b want 0", underflow); end
        for (int i = 0; i < 12; i++) begin feed_data[i] = 24'(i + 1); feed_sof[i] = (i == 0); end
        fork
            feeder(12, 200);
            capture_frame();
        join
        checks++; if (cap_ok !== 1'b1) begin errors++; $display("FAIL stream_capture: got %b want 1", cap_ok); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cap_vals[i] !== 24'(i + 1)) begin errors++; $display("FAIL stream_pix%0d: got %h want %h", i, cap_vals[i], 24'(i + 1)); end
        end
        checks++; if (cap_uf !== 1'b0) begin errors++; $display("FAIL stream_underflow: got %b want 0", cap_uf); end
        checks++; if (cap_fs !== 1) begin errors++; $display("FAIL stream_frame_start: got %0d pulses want 1", cap_fs); end
        $display("test_streaming: %0d checks so far, %0d errors", checks, errors);
    endtask

    task automatic test_starvation();
        bit ok;
        reset_to_blanking();
        for (int i = 0; i < 5; i++) begin feed_data[i] = 24'(i + 1); feed_sof[i] = (i == 0); end
        fork
            feeder(5, 200);
            capture_frame();
        join
        checks++; if (cap_ok !== 1'b1) begin errors++; $display("FAIL starve_capture: got %b want 1", cap_ok); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cap_vals[i] !== ((i < 5) ? 24'(i + 1) : 24'h0)) begin
                errors++; $display("FAIL starve_pix%0d: got %h want %h", i, cap_vals[i], ((i < 5) ? 24'(i + 1) : 24'h0));
            end
        end
        checks++; if (cap_uf !== 1'b1) begin errors++; $display("FAIL starve_underflow: got %b want 1", cap_uf); end
        wait_vsync(ok);
        checks++; if (!ok || underflow !== 1'b1) begin errors++; $display("FAIL starve_sticky: got %b (vsync %b) want 1", underflow, ok); end
        underflow_clr = 1'b1;
        @(negedge clk);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL starve_clear: got %b want 0", underflow); end
        // Clear held through the next frame's first underflow: the set must win.
        wait_frame_start(ok);
        checks++; if (!ok || underflow !== 1'b1) begin errors++; $display("FAIL starve_set_wins: got %b (fs %b) want 1", underflow, ok); end
        wait_vsync(ok);
        checks++; if (!ok || underflow !== 1'b0) begin errors++; $display("FAIL starve_clear_blank: got %b (vsync %b) want 0", underflow, ok); end
        underflow_clr = 1'b0;
        $display("test_starvation: %0d checks so far, %0d errors", checks, errors);
    endtask

    task automatic test_resync();
        reset_to_blanking();
        for (int i = 0; i < 3; i++) begin feed_data[i] = 24'hAA0001 + 24'(i); feed_sof[i] = 1'b0; end
        for (int i = 0; i < 12; i++) begin feed_data[i + 3] = 24'(i + 1); feed_sof[i + 3] = (i == 0); end
        fork
            feeder(15, 200);
            capture_frame();
        join
        checks++; if (cap_ok !== 1'b1) begin errors++; $display("FAIL resync_capture: got %b want 1", cap_ok); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cap_vals[i] !== 24'(i + 1)) begin errors++; $display("FAIL resync_pix%0d: got %h want %h", i, cap_vals[i], 24'(i + 1)); end
        end
        checks++; if (cap_uf !== 1'b0) begin errors++; $display("FAIL resync_underflow: got %b want 0", cap_uf); end
        $display("test_resync: %0d checks so far, %0d errors", checks, errors);
    endtask

    task automatic test_sof_midframe();
        bit ok;
        reset_to_blanking();
        feed_data[0] = 24'h000001; feed_sof[0] = 1'b1;
        feed_data[1] = 24'h000002; feed_sof[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin feed_data[i + 2] = 24'h10 + 24'(i); feed_sof[i + 2] = (i == 0); end
        fork
            feeder(14, 300);
            begin
                capture_frame();
                checks++; if (cap_ok !== 1'b1) begin errors++; $display("FAIL midsof_capture1: got %b want 1", cap_ok); end
                for (int i = 0; i < 12; i++) begin
                    checks++;
                    if (cap_vals[i] !== ((i < 2) ? 24'(i + 1) : 24'h0)) begin
                        errors++; $display("FAIL midsof_f1_pix%0d: got %h want %h", i, cap_vals[i], ((i < 2) ? 24'(i + 1) : 24'h0));
                    end
                end
                checks++; if (cap_uf !== 1'b1) begin errors++; $display("FAIL midsof_f1_underflow: got %b want 1", cap_uf); end
                wait_vsync(ok);
                underflow_clr = 1'b1;
                @(negedge clk);
                underflow_clr = 1'b0;
                checks++; if (!ok || underflow !== 1'b0) begin errors++; $display("FAIL midsof_clear: got %b (vsync %b) want 0", underflow, ok); end
                capture_frame();
                checks++; if (cap_ok !== 1'b1) begin errors++; $display("FAIL midsof_capture2: got %b want 1", cap_ok); end
                for (int i = 0; i < 12; i++) begin
                    checks++;
                    if (cap_vals[i] !== 24'h10 + 24'(i)) begin errors++; $display("FAIL midsof_f2_pix%0d: got %h want %h", i, cap_vals[i], 24'h10 + 24'(i)); end
                end
                checks++; if (cap_uf !== 1'b0) begin errors++; $display("FAIL midsof_f2_underflow: got %b want 0", cap_uf); end
            end
        join
        $display("test_sof_midframe: %0d checks so far, %0d errors", checks, errors);
    endtask

    task automatic test_backpressure_reset();
        bit ok;
        reset_to_blanking();
        for (int i = 0; i < 5; i++) begin feed_data[i] = 24'hB00001 + 24'(i); feed_sof[i] = 1'b1; end
        fork
            feeder(5, 60);
            begin
                repeat (10) @(negedge clk);
                checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", pix_ready); end
                checks++; if (feed_accepted !== 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", feed_accepted); end
                wait_frame_start(ok);
                checks++; if (!ok || RGB !== 24'hB00001) begin errors++; $display("FAIL bp_no_overwrite: got %h (fs %b) want b00001", RGB, ok); end
                repeat (9) @(negedge clk);
                checks++; if (DEN !== 1'b1) begin errors++; $display("FAIL bp_midframe_den: got %b want 1", DEN); end
                reset_n = 1'b0;
                #1;
                checks++; if (DEN !== 1'b0) begin errors++; $display("FAIL mid_rst_den: got %b want 0", DEN); end
                checks++; if (HSD !== 1'b1) begin errors++; $display("FAIL mid_rst_hsd: got %b want 1", HSD); end
                checks++; if (VSD !== 1'b1) begin errors++; $display("FAIL mid_rst_vsd: got %b want 1", VSD); end
                checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", pix_ready); end
                checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL mid_rst_underflow: got %b want 0", underflow); end
            end
        join
        pix_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", pix_ready); end
        wait_frame_start(ok);
        checks++; if (!ok || RGB !== 24'h0) begin errors++; $display("FAIL post_rst_flushed: got %h (fs %b) want 000000", RGB, ok); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL post_rst_underflow: got %b want 1", underflow); end
        $display("test_backpressure_reset: %0d checks so far, %0d errors", checks, errors);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_starvation();
        test_resync();
        test_sof_midframe();
        test_backpressure_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
